// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and address-width helper for the conv
// accelerator and its result reader.
package conv_pkg;
  localparam int CONV_DW    = 32;
  localparam int DIM_W      = 8;
  localparam int CONV_DSIZE = 1024;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_READ,
    RD_FLUSH,
    RD_FIN
  } rd_state_e;

  function automatic int conv_aw(input int dsize);
    return $clog2(dsize) + 1;
  endfunction
endpackage

// File: rtl/conv_rd_skid.sv
// Two-entry result buffer of {data, row_last, last}; entry 0 is the
// registered stream output, so m_valid never depends on m_ready.
module conv_rd_skid #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          push_row_last,
  input  logic          push_last,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  output logic          m_row_last,
  output logic          m_last,
  output logic [1:0]    occ
);
  logic [DW-1:0] d0_q, d0_d, d1_q, d1_d;
  logic          rl0_q, rl0_d, rl1_q, rl1_d;
  logic          ls0_q, ls0_d, ls1_q, ls1_d;
  logic [1:0]    occ_q, occ_d;
  logic          pop;

  assign pop = (occ_q != 2'd0) && m_ready;

  always_comb begin
    d0_d  = d0_q;
    d1_d  = d1_q;
    rl0_d = rl0_q;
    rl1_d = rl1_q;
    ls0_d = ls0_q;
    ls1_d = ls1_q;
    occ_d = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          d0_d = push_data; rl0_d = push_row_last; ls0_d = push_last;
        end else begin
          d1_d = push_data; rl1_d = push_row_last; ls1_d = push_last;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        d0_d = d1_q; rl0_d = rl1_q; ls0_d = ls1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push/pop: the new word lands behind whatever remains.
        if (occ_q == 2'd1) begin
          d0_d = push_data; rl0_d = push_row_last; ls0_d = push_last;
        end else begin
          d0_d = d1_q; rl0_d = rl1_q; ls0_d = ls1_q;
          d1_d = push_data; rl1_d = push_row_last; ls1_d = push_last;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0_q  <= '0;
      d1_q  <= '0;
      rl0_q <= 1'b0;
      rl1_q <= 1'b0;
      ls0_q <= 1'b0;
      ls1_q <= 1'b0;
      occ_q <= 2'd0;
    end else begin
      d0_q  <= d0_d;
      d1_q  <= d1_d;
      rl0_q <= rl0_d;
      rl1_q <= rl1_d;
      ls0_q <= ls0_d;
      ls1_q <= ls1_d;
      occ_q <= occ_d;
    end
  end

  assign m_data     = d0_q;
  assign m_valid    = (occ_q != 2'd0);
  assign m_row_last = rl0_q & m_valid;
  assign m_last     = ls0_q & m_valid;
  assign occ        = occ_q;
endmodule

// File: rtl/conv_result_reader.sv
// Drains a width x height window of the conv result memory as a valid/ready
// stream. Optional macro CONV_RD_RELU_EN clamps negative results to zero.
module conv_result_reader
  import conv_pkg::*;
#(
  parameter int DSIZE = CONV_DSIZE,
  parameter int AW    = conv_aw(DSIZE),
  parameter int DW    = CONV_DW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIM_W-1:0] result_width,
  input  logic [DIM_W-1:0] result_height,
  input  logic [DIM_W-1:0] row_pitch,
  output logic [AW-1:0]    mo_addr,
  input  logic [DW-1:0]    mo_data,
  output logic [DW-1:0]    m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_row_last,
  output logic             m_last,
  output logic             busy,
  output logic             done
);
  rd_state_e        state_q, state_d;
  logic [DIM_W-1:0] w_q, w_d, h_q, h_d, p_q, p_d;
  logic [DIM_W-1:0] x_q, x_d, y_q, y_d;
  logic [AW-1:0]    rb_q, rb_d;
  logic             inflight_q, tag_rl_q, tag_last_q, done_q;
  logic             issue, done_d, x_end, y_end, pop;
  logic [1:0]       occ;
  logic [2:0]       pending;
  logic [DW-1:0]    push_data;

  assign x_end = (x_q == w_q - DIM_W'(1));
  assign y_end = (y_q == h_q - DIM_W'(1));
  assign pop   = m_valid & m_ready;
  // Words that will occupy the buffer after this edge, counting the one in flight.
  assign pending = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    p_d     = p_q;
    x_d     = x_q;
    y_d     = y_q;
    rb_d    = rb_q;
    issue   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (start) begin
          w_d  = result_width;
          h_d  = result_height;
          p_d  = row_pitch;
          x_d  = '0;
          y_d  = '0;
          rb_d = '0;
          state_d = (result_width == '0 || result_height == '0) ? RD_FIN : RD_READ;
        end
      end
      RD_READ: begin
        if (pending < 3'd2) begin
          issue = 1'b1;
          if (x_end) begin
            x_d  = '0;
            y_d  = y_q + DIM_W'(1);
            rb_d = rb_q + AW'(p_q);
            if (y_end) state_d = RD_FLUSH;
          end else begin
            x_d = x_q + DIM_W'(1);
          end
        end
      end
      RD_FLUSH: begin
        if (pop && m_last) state_d = RD_FIN;
      end
      RD_FIN: begin
        done_d  = 1'b1;
        state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RD_IDLE;
      w_q        <= '0;
      h_q        <= '0;
      p_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      rb_q       <= '0;
      inflight_q <= 1'b0;
      tag_rl_q   <= 1'b0;
      tag_last_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      h_q        <= h_d;
      p_q        <= p_d;
      x_q        <= x_d;
      y_q        <= y_d;
      rb_q       <= rb_d;
      inflight_q <= issue;
      tag_rl_q   <= x_end;
      tag_last_q <= x_end & y_end;
      done_q     <= done_d;
    end
  end

`ifdef CONV_RD_RELU_EN
  logic signed [DW-1:0] res_s;
  assign res_s     = mo_data;
  assign push_data = (res_s < 0) ? '0 : mo_data;
`else
  assign push_data = mo_data;
`endif

  conv_rd_skid #(.DW(DW)) u_skid (
    .clk           (clk),
    .rst_n         (rst_n),
    .push          (inflight_q),
    .push_data     (push_data),
    .push_row_last (tag_rl_q),
    .push_last     (tag_last_q),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_row_last    (m_row_last),
    .m_last        (m_last),
    .occ           (occ)
  );

  assign mo_addr = rb_q + AW'(x_q);
  assign busy    = (state_q != RD_IDLE);
  assign done    = done_q;
endmodule

// File: tb/tb_conv_result_reader.sv
// Scoreboard bench for conv_result_reader: a registered memory model feeds
// mo_data, expected beats are queued at start and compared at each handshake.
module tb_conv_result_reader;
  localparam int AW = 11;
  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          rl;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    result_width = '0, result_height = '0, row_pitch = '0;
  logic [AW-1:0] mo_addr;
  logic [DW-1:0] mo_data = '0;
  logic [DW-1:0] m_data;
  logic          m_valid, m_ready = 1'b0, m_row_last, m_last, busy, done;

  logic [DW-1:0] mem [2048];
  beat_t         exp_q[$];
  int            checks = 0;
  int            failures = 0;

  conv_result_reader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .result_width  (result_width),
    .result_height (result_height),
    .row_pitch     (row_pitch),
    .mo_addr       (mo_addr),
    .mo_data       (mo_data),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_row_last    (m_row_last),
    .m_last        (m_last),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mo_data <= mem[mo_addr];

  function automatic logic [DW-1:0] model_val(input logic [DW-1:0] v);
`ifdef CONV_RD_RELU_EN
    if ($signed(v) < 0) return '0;
`endif
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_data !== '0 || mo_addr !== '0 || m_row_last !== 1'b0 ||
        m_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b data=%h addr=%h rl=%b last=%b busy=%b done=%b, want all 0",
               m_valid, m_data, mo_addr, m_row_last, m_last, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Runs one frame from a start pulse to done; bp randomises m_ready,
  // restart_k (>=0) pulses start again at that cycle with other dimensions.
  task automatic test_drain(input string name, input int w, input int h, input int p,
                            input bit bp, input int restart_k);
    int    k, first_k, done_k, n_beats, n_exp;
    bit    have_hold;
    beat_t hold, obs, eb;
    exp_q.delete();
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        eb.d    = model_val(mem[(y * p + x) % 2048]);
        eb.rl   = (x == w - 1);
        eb.last = (x == w - 1) && (y == h - 1);
        exp_q.push_back(eb);
      end
    n_exp = exp_q.size();
    result_width  = 8'(w);
    result_height = 8'(h);
    row_pitch     = 8'(p);
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    k = 0; first_k = -1; done_k = -1; n_beats = 0; have_hold = 1'b0; hold = '0;
    while (done_k < 0 && k < 4000) begin
      @(negedge clk);
      obs = beat_t'({m_data, m_row_last, m_last});
      if (k == 0) begin
        checks++;
        if (busy !== 1'b1 || mo_addr !== '0) begin
          failures++;
          $display("FAIL %s first_cycle: got busy=%b addr=%h, want busy=1 addr=0", name, busy, mo_addr);
        end
      end
      if (m_valid && first_k < 0) first_k = k;
      if (have_hold) begin
        checks++;
        if (m_valid !== 1'b1 || obs !== hold) begin
          failures++;
          $display("FAIL %s stall_stable k=%0d: got v=%b beat=%h, want v=1 beat=%h", name, k, m_valid, obs, hold);
        end
      end
      have_hold = m_valid && !m_ready;
      hold = obs;
      if (m_valid && m_ready) begin
        n_beats++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL %s extra_beat k=%0d: got %h, want no beat", name, k, obs);
        end else begin
          eb = exp_q.pop_front();
          if (obs !== eb) begin
            failures++;
            $display("FAIL %s beat%0d: got d=%h rl=%b last=%b, want d=%h rl=%b last=%b",
                     name, n_beats - 1, obs.d, obs.rl, obs.last, eb.d, eb.rl, eb.last);
          end
        end
      end
      if (done) begin
        done_k = k;
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL %s busy_at_done: got %b, want 0", name, busy);
        end
      end
      @(posedge clk);
      k++;
      #1;
      start = (k == restart_k);
      if (k == restart_k) begin
        result_width = 8'd3; result_height = 8'd3; row_pitch = 8'd1;
      end
      m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    start = 1'b0;
    checks++;
    if (first_k != (n_exp == 0 ? -1 : 2)) begin
      failures++;
      $display("FAIL %s first_valid_cycle: got %0d, want %0d", name, first_k, n_exp == 0 ? -1 : 2);
    end
    checks++;
    if (bp ? (done_k < n_exp + 3) : (done_k != (n_exp == 0 ? 1 : n_exp + 3))) begin
      failures++;
      $display("FAIL %s done_cycle: got %0d, want %0d", name, done_k, n_exp == 0 ? 1 : n_exp + 3);
    end
    checks++;
    if (n_beats != n_exp || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s beat_count: got %0d (left %0d), want %0d", name, n_beats, exp_q.size(), n_exp);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s done_pulse_end: got done=%b busy=%b, want 0 0", name, done, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int hs = 0;
    int cyc = 0;
    result_width = 8'd59; result_height = 8'd9; row_pitch = 8'd62;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    m_ready = 1'b1;
    while (hs < 10 && cyc < 100) begin
      @(negedge clk);
      if (m_valid && m_ready) hs++;
      if (hs < 10) begin
        @(posedge clk);
        #1;
      end
      cyc++;
    end
    checks++;
    if (hs != 10) begin
      failures++;
      $display("FAIL reset_mid_beats: got %0d, want 10", hs);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_data !== '0 || mo_addr !== '0 || m_row_last !== 1'b0 ||
        m_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got valid=%b data=%h addr=%h rl=%b last=%b busy=%b done=%b, want all 0",
               m_valid, m_data, mo_addr, m_row_last, m_last, busy, done);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_drain("post_reset", 5, 3, 7, 1'b0, -1);
  endtask

  task automatic test_relu();
    mem[0] = -32'sd5;
    mem[1] = 32'd7;
    mem[2] = 32'h8000_0000;
    mem[3] = 32'd3;
    test_drain("relu", 4, 1, 4, 1'b0, -1);
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = 32'(a);
    test_reset();
    test_drain("basic", 59, 9, 62, 1'b0, -1);
    test_drain("backpressure", 59, 9, 62, 1'b1, -1);
    test_drain("zero_size", 0, 5, 3, 1'b0, -1);
    test_drain("overlap_pitch", 6, 4, 3, 1'b0, -1);
    test_drain("restart_ignored", 59, 9, 62, 1'b0, 100);
    test_reset_mid();
    test_relu();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
